// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared arbiter state type and strobe-width helpers
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam int BYTE_BITS = 8;

  function automatic int strb_width(input int data_width);
    return data_width / BYTE_BITS;
  endfunction

  // An all-zero strobe marks a read transfer.
  localparam logic READ_WHEN_STRB_ZERO = 1'b1;

endpackage

// File: rtl/apb_arb_picker.sv
// rtl/apb_arb_picker.sv - combinational winner search; ARB_FIXED_PRIO_EN selects fixed priority
module apb_arb_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     rr_ptr_i,
  output logic [IDW-1:0]     winner_o,
  output logic               valid_o
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^rr_ptr_i;

  // Descending scan so the lowest requesting index is written last.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        valid_o  = 1'b1;
        winner_o = IDW'(k);
      end
    end
  end
`else
  always_comb begin
    int             pos;
    logic [IDW-1:0] idx;
    valid_o  = 1'b0;
    winner_o = '0;
    pos      = 0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = IDW'(pos);
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end
`endif

endmodule

// File: rtl/apb_bus_arbiter.sv
// rtl/apb_bus_arbiter.sv - one-transfer-per-grant arbiter in front of an APB requester
// Build option: ARB_FIXED_PRIO_EN (fixed priority, rr pointer held at 0).
module apb_bus_arbiter
  import apb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int STRB       = strb_width(DATA_WIDTH),
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [NUM_REQ-1:0]         req_ena,
  input  logic [NUM_REQ*STRB-1:0]    req_wstb,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_WIDTH-1:0]      req_rdata,
  output logic                       req_slverr,
  output logic                       m_ena,
  output logic [STRB-1:0]            m_wstb,
  output logic [ADDR_WIDTH-1:0]      m_addr,
  output logic [DATA_WIDTH-1:0]      m_wdata,
  input  logic                       m_ready,
  input  logic [DATA_WIDTH-1:0]      m_rdata,
  input  logic                       m_slverr,
  output logic [IDW-1:0]             grant_id,
  output logic                       busy
);

  arb_state_e              state_q, state_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic                    m_ena_q, m_ena_d;
  logic [STRB-1:0]         wstb_q, wstb_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    is_read_q, is_read_d;
  logic [NUM_REQ-1:0]      ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    slverr_q, slverr_d;

  logic [IDW-1:0]          win_idx;
  logic                    win_valid;

  logic [STRB-1:0]         wstb_a  [NUM_REQ];
  logic [ADDR_WIDTH-1:0]   addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign wstb_a[g]  = req_wstb[g*STRB +: STRB];
    assign addr_a[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  apb_arb_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i    (req_ena),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (win_idx),
    .valid_o  (win_valid)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    m_ena_d   = m_ena_q;
    wstb_d    = wstb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_read_d = is_read_q;
    ready_d   = '0;
    rdata_d   = rdata_q;
    slverr_d  = slverr_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d   = win_idx;
          wstb_d    = wstb_a[win_idx];
          addr_d    = addr_a[win_idx];
          wdata_d   = wdata_a[win_idx];
          is_read_d = (~|wstb_a[win_idx]) == READ_WHEN_STRB_ZERO;
          m_ena_d   = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // Client-side inputs are not looked at here: payload is frozen until completion.
        if (m_ready) begin
          m_ena_d          = 1'b0;
          ready_d[grant_q] = 1'b1;
          slverr_d         = m_slverr;
          if (is_read_q) rdata_d = m_rdata;
`ifdef ARB_FIXED_PRIO_EN
          rr_ptr_d = '0;
`else
          rr_ptr_d = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      m_ena_q   <= 1'b0;
      wstb_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      is_read_q <= 1'b0;
      ready_q   <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      m_ena_q   <= m_ena_d;
      wstb_q    <= wstb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_read_q <= is_read_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
    end
  end

  assign req_ready  = ready_q;
  assign req_rdata  = rdata_q;
  assign req_slverr = slverr_q;
  assign m_ena      = m_ena_q;
  assign m_wstb     = wstb_q;
  assign m_addr     = addr_q;
  assign m_wdata    = wdata_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// tb/tb_apb_bus_arbiter.sv - scoreboard bench for apb_bus_arbiter
module tb_apb_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            pclk;
  logic            presetn;
  logic [N-1:0]    req_ena;
  logic [N*SW-1:0] req_wstb;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   req_rdata;
  logic            req_slverr;
  logic            m_ena;
  logic [SW-1:0]   m_wstb;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_ready;
  logic [DW-1:0]   m_rdata;
  logic            m_slverr;
  logic [1:0]      grant_id;
  logic            busy;

  apb_bus_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_ena(req_ena), .req_wstb(req_wstb), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_rdata(req_rdata), .req_slverr(req_slverr),
    .m_ena(m_ena), .m_wstb(m_wstb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .m_slverr(m_slverr),
    .grant_id(grant_id), .busy(busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          failures;
  int          exp_ptr;
  logic [31:0] last_rdata;

  function automatic int model_pick(input logic [3:0] r, input int ptr);
    logic [3:0] rv;
    rv = r;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (rv[i]) return i;
`else
    for (int k = 0; k < N; k++) if (rv[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return -1;
  endfunction

  function automatic int model_advance(input int id);
`ifdef ARB_FIXED_PRIO_EN
    return 0;
`else
    return (id + 1) % N;
`endif
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_m_ena(output int low, output bit ok);
    low = 0;
    ok  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (m_ena === 1'b1) begin
        ok = 1'b1;
        return;
      end
      step();
      low++;
    end
  endtask

  // Completes the granted transfer and records what the client should see.
  task automatic respond(input logic [31:0] d, input logic e, input int id, input bit is_read);
    exp_t x;
    if (is_read) last_rdata = d;
    x.id = id; x.rdata = last_rdata; x.err = e;
    sb.push_back(x);
    m_ready = 1'b1; m_rdata = d; m_slverr = e;
    step();
    m_ready = 1'b0; m_rdata = $urandom; m_slverr = 1'b0;
    exp_ptr = model_advance(id);
  endtask

  task automatic set_client(input int i, input logic [31:0] a, input logic [3:0] s, input logic [31:0] w);
    req_addr[i*AW +: AW]  = a;
    req_wstb[i*SW +: SW]  = s;
    req_wdata[i*DW +: DW] = w;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    step(); step();
    checks++;
    if ({m_ena, m_wstb, m_addr, m_wdata, req_ready, req_rdata, req_slverr, grant_id, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs m_ena=%0b req_ready=%b grant=%0d busy=%0b m_addr=%h req_rdata=%h expected all zero",
               m_ena, req_ready, grant_id, busy, m_addr, req_rdata);
    end
    presetn = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || m_ena !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%0b m_ena=%0b expected 0 0", busy, m_ena);
    end
    exp_ptr = 0;
    last_rdata = '0;
  endtask

  task automatic test_contention();
    int low, exp_id;
    bit ok;
    exp_t e;
    for (int i = 0; i < N; i++) set_client(i, 32'h1000 + i * 4, 4'h0, 32'h0);
    req_ena = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_m_ena(low, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL contention_timeout round=%0d m_ena=%0b expected 1", n, m_ena);
      end
      exp_id = model_pick(req_ena, exp_ptr);
      checks++;
      if (grant_id !== exp_id[1:0] || m_addr !== 32'h1000 + exp_id * 4) begin
        failures++;
        $display("FAIL contention_grant round=%0d grant=%0d addr=%h expected %0d %h",
                 n, grant_id, m_addr, exp_id, 32'h1000 + exp_id * 4);
      end
      if (n > 0) begin
        checks++;
        if (low < 2) begin
          failures++;
          $display("FAIL contention_gap round=%0d low_cycles=%0d expected >=2", n, low);
        end
      end
      respond(32'hA000_0000 + n, 1'b0, exp_id, 1'b1);
      e = sb.pop_front();
      checks++;
      if (req_ready !== (4'b1 << e.id) || req_rdata !== e.rdata || req_slverr !== e.err) begin
        failures++;
        $display("FAIL contention_resp round=%0d ready=%b rdata=%h err=%0b expected %b %h %0b",
                 n, req_ready, req_rdata, req_slverr, 4'b1 << e.id, e.rdata, e.err);
      end
    end
    req_ena = 4'h0;
    step(); step();
  endtask

  task automatic test_single_read();
    exp_t e;
    set_client(2, 32'h100, 4'h0, 32'h0);
    req_ena = 4'b0100;
    step();
    checks++;
    if (m_ena !== 1'b1 || m_addr !== 32'h100 || grant_id !== 2'd2 || m_wstb !== 4'h0) begin
      failures++;
      $display("FAIL read_issue m_ena=%0b addr=%h grant=%0d wstb=%h expected 1 00000100 2 0",
               m_ena, m_addr, grant_id, m_wstb);
    end
    respond(32'hDEADBEEF, 1'b0, 2, 1'b1);
    e = sb.pop_front();
    checks++;
    if (req_ready !== (4'b1 << e.id) || req_rdata !== e.rdata || req_slverr !== e.err) begin
      failures++;
      $display("FAIL read_resp ready=%b rdata=%h err=%0b expected %b %h %0b",
               req_ready, req_rdata, req_slverr, 4'b1 << e.id, e.rdata, e.err);
    end
    req_ena = 4'h0;
    step();
    checks++;
    if (req_ready !== 4'h0 || req_rdata !== 32'hDEADBEEF || busy !== 1'b0) begin
      failures++;
      $display("FAIL read_pulse_end ready=%b rdata=%h busy=%0b expected 0000 deadbeef 0",
               req_ready, req_rdata, busy);
    end
  endtask

  task automatic test_error();
    exp_t e;
    set_client(1, 32'h200, 4'hF, 32'h1234_5678);
    req_ena = 4'b0010;
    step();
    checks++;
    if (m_ena !== 1'b1 || m_wstb !== 4'hF || m_wdata !== 32'h1234_5678 || grant_id !== 2'd1) begin
      failures++;
      $display("FAIL error_issue m_ena=%0b wstb=%h wdata=%h grant=%0d expected 1 f 12345678 1",
               m_ena, m_wstb, m_wdata, grant_id);
    end
    respond(32'h5555_5555, 1'b1, 1, 1'b0);
    e = sb.pop_front();
    checks++;
    if (req_ready !== (4'b1 << e.id) || req_rdata !== e.rdata || req_slverr !== e.err) begin
      failures++;
      $display("FAIL error_resp ready=%b rdata=%h err=%0b expected %b %h %0b",
               req_ready, req_rdata, req_slverr, 4'b1 << e.id, e.rdata, e.err);
    end
    req_ena = 4'h0;
    step();
  endtask

  task automatic test_stall();
    exp_t e;
    set_client(0, 32'h40, 4'h0, 32'h0);
    req_ena = 4'b0001;
    step();
    for (int c = 0; c < 20; c++) begin
      req_addr[0 +: AW] = $urandom;
      if (c == 10) req_ena = 4'b0000;
      step();
      checks++;
      if (m_addr !== 32'h40 || m_ena !== 1'b1 || req_ready !== 4'h0) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d addr=%h m_ena=%0b ready=%b expected 00000040 1 0000",
                 c, m_addr, m_ena, req_ready);
      end
    end
    respond(32'hC0FFEE00, 1'b0, 0, 1'b1);
    e = sb.pop_front();
    checks++;
    if (req_ready !== (4'b1 << e.id) || req_rdata !== e.rdata || req_slverr !== e.err) begin
      failures++;
      $display("FAIL stall_resp ready=%b rdata=%h err=%0b expected %b %h %0b",
               req_ready, req_rdata, req_slverr, 4'b1 << e.id, e.rdata, e.err);
    end
    step();
  endtask

  task automatic test_reset_mid_busy();
    exp_t e;
    int exp_id;
    for (int i = 0; i < N; i++) set_client(i, 32'h3000 + i * 4, 4'h0, 32'h0);
    req_ena = 4'b0100;
    step();
    #2 presetn = 1'b0;
    #1;
    checks++;
    if ({m_ena, m_wstb, m_addr, m_wdata, req_ready, req_rdata, req_slverr, grant_id, busy} !== '0) begin
      failures++;
      $display("FAIL reset_async m_ena=%0b ready=%b grant=%0d busy=%0b rdata=%h expected all zero",
               m_ena, req_ready, grant_id, busy, req_rdata);
    end
    req_ena = 4'hF;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (req_ready !== 4'h0 || m_ena !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_pulse cycle=%0d ready=%b m_ena=%0b expected 0000 0", c, req_ready, m_ena);
      end
    end
    presetn = 1'b1;
    exp_ptr = 0;
    last_rdata = '0;
    step();
    exp_id = model_pick(req_ena, exp_ptr);
    checks++;
    if (m_ena !== 1'b1 || grant_id !== exp_id[1:0] || sb.size() != 0) begin
      failures++;
      $display("FAIL reset_regrant m_ena=%0b grant=%0d sb=%0d expected 1 %0d 0",
               m_ena, grant_id, sb.size(), exp_id);
    end
    respond(32'h0BAD_F00D, 1'b0, exp_id, 1'b1);
    e = sb.pop_front();
    checks++;
    if (req_ready !== (4'b1 << e.id) || req_rdata !== e.rdata) begin
      failures++;
      $display("FAIL reset_resp ready=%b rdata=%h expected %b %h",
               req_ready, req_rdata, 4'b1 << e.id, e.rdata);
    end
    req_ena = 4'h0;
    step(); step();
  endtask

  task automatic test_pair_priority();
    int low, exp_id;
    bit ok;
    exp_t e;
    for (int i = 0; i < N; i++) set_client(i, 32'h4000 + i * 4, 4'h0, 32'h0);
    req_ena = 4'b1001;
    for (int n = 0; n < 4; n++) begin
      if (n == 3) req_ena[0] = 1'b0;
      wait_m_ena(low, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL pair_timeout round=%0d m_ena=%0b expected 1", n, m_ena);
      end
      exp_id = model_pick(req_ena, exp_ptr);
      checks++;
      if (grant_id !== exp_id[1:0]) begin
        failures++;
        $display("FAIL pair_grant round=%0d grant=%0d expected %0d", n, grant_id, exp_id);
      end
      respond(32'h7700_0000 + n, 1'b0, exp_id, 1'b1);
      e = sb.pop_front();
      checks++;
      if (req_ready !== (4'b1 << e.id) || req_rdata !== e.rdata) begin
        failures++;
        $display("FAIL pair_resp round=%0d ready=%b rdata=%h expected %b %h",
                 n, req_ready, req_rdata, 4'b1 << e.id, e.rdata);
      end
    end
    req_ena = 4'h0;
    step(); step();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    req_ena   = '0;
    req_wstb  = '0;
    req_addr  = '0;
    req_wdata = '0;
    m_ready   = 1'b0;
    m_rdata   = '0;
    m_slverr  = 1'b0;
    presetn   = 1'b0;
    test_reset();
    test_contention();
    test_single_read();
    test_error();
    test_stall();
    test_reset_mid_busy();
    test_pair_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
